// File: rtl/oled_pkg.sv
// Shared constants, FSM state type and command-payload helper for the OLED text renderer.
package oled_pkg;

   localparam logic [7:0] OLED_CMD_CTRL  = 8'h00;
   localparam logic [7:0] OLED_DATA_CTRL = 8'h40;
   localparam logic [7:0] OLED_PAGE_BASE = 8'hB0;
   localparam int         OLED_COLS      = 128;
   localparam int         OLED_PAGES     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_FETCH,
      ST_LOAD,
      ST_DATA,
      ST_ADV,
      ST_FIN
   } state_e;

   // Command sequence per glyph page: set page, column low nibble, column high bits.
   function automatic logic [7:0] cmd_payload(input logic [1:0] sel,
                                              input logic [6:0] col,
                                              input logic [2:0] page);
      case (sel)
         2'd0:    cmd_payload = OLED_PAGE_BASE | {5'd0, page};
         2'd1:    cmd_payload = {4'h0, col[3:0]};
         default: cmd_payload = {4'h1, 1'b0, col[6:4]};
      endcase
   endfunction

endpackage

// File: rtl/oled_cursor.sv
// Text cursor: holds the current glyph origin and computes the next origin with line wrap.
module oled_cursor
   import oled_pkg::*;
#(
   parameter int FONT_W     = 8,
   parameter int FONT_PAGES = 2
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       load_i,
   input  logic       step_i,
   input  logic [6:0] x_i,
   input  logic [2:0] y_i,
   output logic [6:0] cur_x_o,
   output logic [2:0] cur_y_o,
   output logic [6:0] nxt_x_o,
   output logic [2:0] nxt_y_o
);

   logic [6:0] x_q, x_d;
   logic [2:0] y_q, y_d;
   logic [7:0] reach;
   logic       wrap;

   // A glyph fits on this line only if a further whole glyph would still fit after it.
   assign reach   = {1'b0, x_q} + 8'(2 * FONT_W);
   assign wrap    = reach > 8'(OLED_COLS);
   assign nxt_x_o = wrap ? 7'd0 : 7'({1'b0, x_q} + 8'(FONT_W));
   assign nxt_y_o = wrap ? 3'(y_q + 3'(FONT_PAGES)) : y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (load_i) begin
         x_d = x_i;
         y_d = y_i;
      end else if (step_i) begin
         x_d = nxt_x_o;
         y_d = nxt_y_o;
      end
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign cur_x_o = x_q;
   assign cur_y_o = y_q;

endmodule

// File: rtl/oled_text_gen.sv
// Multi-character OLED text renderer: fetches glyph columns from a font ROM and
// emits one 24-bit I2C frame per command/data byte, with line wrap, invert and abort.
module oled_text_gen
   import oled_pkg::*;
#(
   parameter int          FONT_W     = 8,
   parameter int          FONT_PAGES = 2,
   parameter int          MAX_LEN    = 16,
   parameter int          LEN_W      = 6,
   parameter logic [7:0]  I2C_ADDR   = 8'h78
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [6:0]       x,
   input  logic [2:0]       y,
   input  logic             invert,
   input  logic             abort,
   output logic [LEN_W-1:0] str_idx,
   input  logic [7:0]       str_char,
   output logic [7:0]       font_ascii,
   output logic [1:0]       font_page,
   output logic [3:0]       font_col,
   input  logic [7:0]       font_byte,
   output logic             iic_wr_req,
   output logic [23:0]      iic_wr_data,
   input  logic             iic_wr_done,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, ci_q, ci_d, len_c;
   logic [1:0]       pg_q, pg_d, cmd_q, cmd_d;
   logic [3:0]       cc_q, cc_d;
   logic             inv_q, inv_d, abort_q, abort_d;
   logic [23:0]      data_q, data_d;
   logic             req_q, busy_q, done_q;
   logic             cur_load, cur_step, abort_any, wr_ack;
   logic [6:0]       cur_x, nxt_x;
   logic [2:0]       cur_y, nxt_y;

   oled_cursor #(
      .FONT_W     (FONT_W),
      .FONT_PAGES (FONT_PAGES)
   ) u_cursor (
      .clk_50m (clk_50m),
      .rst     (rst),
      .load_i  (cur_load),
      .step_i  (cur_step),
      .x_i     (x),
      .y_i     (y),
      .cur_x_o (cur_x),
      .cur_y_o (cur_y),
      .nxt_x_o (nxt_x),
      .nxt_y_o (nxt_y)
   );

   assign len_c     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   assign abort_any = abort_q | abort;
   // req_q is high exactly in CMD/DATA, so a stray done outside a frame is ignored.
   assign wr_ack    = iic_wr_done & req_q;

   // NOTE: every variable gets its default before the case so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      ci_d     = ci_q;
      pg_d     = pg_q;
      cc_d     = cc_q;
      cmd_d    = cmd_q;
      inv_d    = inv_q;
      data_d   = data_q;
      cur_load = 1'b0;
      cur_step = 1'b0;
      abort_d  = (state_q == ST_IDLE || state_q == ST_FIN) ? 1'b0 : abort_any;

      case (state_q)
         ST_IDLE: if (start) begin
            inv_d    = invert;
            len_d    = len_c;
            ci_d     = '0;
            pg_d     = '0;
            cc_d     = '0;
            cmd_d    = '0;
            cur_load = 1'b1;
            data_d   = {I2C_ADDR, OLED_CMD_CTRL, cmd_payload(2'd0, x, y)};
            state_d  = (len_c == '0) ? ST_FIN : ST_CMD;
         end
         ST_CMD: if (wr_ack) begin
            if (abort_any) begin
               state_d = ST_FIN;
            end else if (cmd_q == 2'd2) begin
               state_d = ST_FETCH;
            end else begin
               cmd_d  = 2'(cmd_q + 2'd1);
               data_d = {I2C_ADDR, OLED_CMD_CTRL,
                         cmd_payload(2'(cmd_q + 2'd1), cur_x, 3'(cur_y + {1'b0, pg_q}))};
            end
         end
         ST_FETCH: state_d = abort_any ? ST_FIN : ST_LOAD;
         ST_LOAD: begin
            if (abort_any) begin
               state_d = ST_FIN;
            end else begin
               data_d  = {I2C_ADDR, OLED_DATA_CTRL, font_byte ^ {8{inv_q}}};
               state_d = ST_DATA;
            end
         end
         ST_DATA: if (wr_ack) begin
            if (abort_any) begin
               state_d = ST_FIN;
            end else if (cc_q < 4'(FONT_W - 1)) begin
               cc_d    = 4'(cc_q + 4'd1);
               state_d = ST_FETCH;
            end else if (pg_q < 2'(FONT_PAGES - 1)) begin
               pg_d    = 2'(pg_q + 2'd1);
               cc_d    = '0;
               cmd_d   = '0;
               data_d  = {I2C_ADDR, OLED_CMD_CTRL,
                          cmd_payload(2'd0, cur_x, 3'(cur_y + {1'b0, pg_q} + 3'd1))};
               state_d = ST_CMD;
            end else begin
               cc_d    = '0;
               state_d = ST_ADV;
            end
         end
         ST_ADV: begin
            ci_d = LEN_W'(ci_q + 1'b1);
            pg_d = '0;
            if (abort_any || LEN_W'(ci_q + 1'b1) == len_q) begin
               state_d = ST_FIN;
            end else begin
               cur_step = 1'b1;
               cmd_d    = '0;
               data_d   = {I2C_ADDR, OLED_CMD_CTRL, cmd_payload(2'd0, nxt_x, nxt_y)};
               state_d  = ST_CMD;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         ci_q    <= '0;
         pg_q    <= '0;
         cc_q    <= '0;
         cmd_q   <= '0;
         inv_q   <= 1'b0;
         abort_q <= 1'b0;
         data_q  <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ci_q    <= ci_d;
         pg_q    <= pg_d;
         cc_q    <= cc_d;
         cmd_q   <= cmd_d;
         inv_q   <= inv_d;
         abort_q <= abort_d;
         data_q  <= data_d;
         req_q   <= (state_d == ST_CMD) || (state_d == ST_DATA);
         busy_q  <= (state_d != ST_IDLE) && (state_d != ST_FIN);
         done_q  <= (state_d == ST_FIN);
      end
   end

   assign str_idx     = ci_q;
   assign font_ascii  = (state_q == ST_FETCH) ? str_char : 8'h00;
   assign font_page   = pg_q;
   assign font_col    = cc_q;
   assign iic_wr_req  = req_q;
   assign iic_wr_data = data_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_oled_text_gen.sv
// Self-checking bench: string buffer, 1-cycle font ROM and an acking I2C writer
// that pops expected frames from a scoreboard queue built by a reference model.
module tb_oled_text_gen;

   localparam int FW = 8;
   localparam int FP = 2;
   localparam int ML = 16;

   logic        clk_50m = 1'b0;
   logic        rst, start, invert, abort, iic_wr_done;
   logic [5:0]  len, str_idx;
   logic [6:0]  x;
   logic [2:0]  y;
   logic [7:0]  str_char, font_ascii, font_byte;
   logic [1:0]  font_page;
   logic [3:0]  font_col;
   logic        iic_wr_req, busy, done;
   logic [23:0] iic_wr_data;

   logic [7:0]  str_mem [0:63];
   logic [23:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;
   int          frames_seen = 0;
   int          ack_delay = 3;
   int          rom_mode = 0;

   always #10 clk_50m = ~clk_50m;

   oled_text_gen #(
      .FONT_W (FW), .FONT_PAGES (FP), .MAX_LEN (ML), .LEN_W (6), .I2C_ADDR (8'h78)
   ) dut (
      .clk_50m (clk_50m), .rst (rst), .start (start), .len (len), .x (x), .y (y),
      .invert (invert), .abort (abort), .str_idx (str_idx), .str_char (str_char),
      .font_ascii (font_ascii), .font_page (font_page), .font_col (font_col),
      .font_byte (font_byte), .iic_wr_req (iic_wr_req), .iic_wr_data (iic_wr_data),
      .iic_wr_done (iic_wr_done), .busy (busy), .done (done)
   );

   function automatic logic [7:0] rom_fn(input logic [7:0] a, input logic [1:0] p,
                                         input logic [3:0] c);
      case (rom_mode)
         0:       return {4'h0, c};
         1:       return 8'h3C;
         default: return a ^ {2'b00, p, c};
      endcase
   endfunction

   assign str_char = str_mem[str_idx];
   always @(posedge clk_50m) font_byte <= rom_fn(font_ascii, font_page, font_col);

   // Writer model: acks each frame ack_delay cycles after req, checks stability and content.
   initial begin : writer
      int          cnt;
      logic [23:0] held, e;
      cnt = 0;
      held = '0;
      iic_wr_done = 1'b0;
      forever begin
         @(posedge clk_50m); #1;
         iic_wr_done = 1'b0;
         if (iic_wr_req) begin
            if (cnt == 0) begin
               held = iic_wr_data;
            end else begin
               checks++;
               if (iic_wr_data !== held) begin
                  failures++;
                  $display("FAIL frame_stable got=%h want=%h", iic_wr_data, held);
               end
            end
            cnt++;
            if (cnt >= ack_delay) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL frame_unexpected got=%h want=none", iic_wr_data);
               end else begin
                  e = exp_q.pop_front();
                  if (iic_wr_data !== e) begin
                     failures++;
                     $display("FAIL frame got=%h want=%h", iic_wr_data, e);
                  end
               end
               frames_seen++;
               iic_wr_done = 1'b1;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clk_50m);
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // Reference model of the whole frame stream for one request.
   task automatic push_expected(input int n, input logic [6:0] x0, input logic [2:0] y0,
                                input logic inv);
      int cx, cy, nc;
      nc = (n > ML) ? ML : n;
      cx = int'(x0);
      cy = int'(y0);
      for (int c = 0; c < nc; c++) begin
         for (int p = 0; p < FP; p++) begin
            exp_q.push_back({8'h78, 8'h00, 8'hB0 | {5'd0, 3'(cy + p)}});
            exp_q.push_back({8'h78, 8'h00, {4'h0, 4'(cx)}});
            exp_q.push_back({8'h78, 8'h00, 8'h10 | {5'd0, 3'(cx >> 4)}});
            for (int col = 0; col < FW; col++)
               exp_q.push_back({8'h78, 8'h40,
                                rom_fn(str_mem[c], 2'(p), 4'(col)) ^ {8{inv}}});
         end
         if (c < nc - 1) begin
            if (cx + 2 * FW > 128) begin
               cx = 0;
               cy = (cy + FP) % 8;
            end else begin
               cx = cx + FW;
            end
         end
      end
   endtask

   task automatic start_req(input int n, input logic [6:0] x0, input logic [2:0] y0,
                            input logic inv);
      @(posedge clk_50m); #1;
      len = 6'(n); x = x0; y = y0; invert = inv; start = 1'b1;
      @(posedge clk_50m); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk_50m); #1;
      end
   endtask

   // Full request: start, wait for done, check frame count, queue drained, single done.
   task automatic run_req(input string name, input int n, input logic [6:0] x0,
                          input logic [2:0] y0, input logic inv, input int nframes);
      bit ok;
      int base, extra_done;
      push_expected(n, x0, y0, inv);
      base = frames_seen;
      start_req(n, x0, y0, inv);
      wait_done(6000, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_done got=timeout want=pulse", name);
      end
      checks++;
      if ((frames_seen - base) != nframes || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_frames got=%0d left=%0d want=%0d", name, frames_seen - base,
                  exp_q.size(), nframes);
      end
      extra_done = 0;
      repeat (4) begin
         @(posedge clk_50m); #1;
         if (done || busy || iic_wr_req) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin
         failures++;
         $display("FAIL %s_idle_after got=%0d want=0", name, extra_done);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk_50m);
      #1;
      checks++;
      if ({iic_wr_req, busy, done} !== 3'b000 || iic_wr_data !== 24'h0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b/%h want=000/000000", {iic_wr_req, busy, done},
                  iic_wr_data);
      end
      checks++;
      if (str_idx !== 6'd0 || font_ascii !== 8'd0 || font_page !== 2'd0 || font_col !== 4'd0) begin
         failures++;
         $display("FAIL reset_font got=%h/%h/%h/%h want=0", str_idx, font_ascii, font_page,
                  font_col);
      end
      @(negedge clk_50m);
      rst = 1'b0;
   endtask

   task automatic test_single_char();
      rom_mode = 0;
      ack_delay = 3;
      run_req("single", 1, 7'd5, 3'd2, 1'b0, 22);
   endtask

   task automatic test_wrap();
      rom_mode = 2;
      run_req("wrap", 3, 7'd112, 3'd1, 1'b0, 66);
   endtask

   task automatic test_invert_and_empty();
      int done_cnt, req_hi, busy_hi, done_at;
      rom_mode = 1;
      run_req("invert", 1, 7'd40, 3'd0, 1'b1, 22);
      @(posedge clk_50m); #1;
      len = 6'd0; start = 1'b1;
      done_cnt = 0; req_hi = 0; busy_hi = 0; done_at = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk_50m); #1;
         start = 1'b0;
         if (done) begin
            done_cnt++;
            done_at = i;
         end
         if (iic_wr_req) req_hi++;
         if (busy) busy_hi++;
      end
      checks++;
      if (done_cnt != 1 || done_at > 2) begin
         failures++;
         $display("FAIL empty_done got=%0d@%0d want=1@<=2", done_cnt, done_at);
      end
      checks++;
      if (req_hi != 0 || busy_hi != 0) begin
         failures++;
         $display("FAIL empty_quiet got=req%0d/busy%0d want=0/0", req_hi, busy_hi);
      end
   endtask

   task automatic test_clamp();
      rom_mode = 2;
      ack_delay = 2;
      run_req("clamp", 20, 7'd0, 3'd0, 1'b0, ML * FP * (3 + FW));
      ack_delay = 3;
   endtask

   task automatic test_page_wrap();
      rom_mode = 2;
      @(posedge clk_50m); #1;
      abort = 1'b1;
      @(posedge clk_50m); #1;
      abort = 1'b0;
      run_req("page_wrap", 1, 7'd64, 3'd7, 1'b0, 22);
   endtask

   task automatic test_abort();
      bit ok, found;
      int base, req_hi;
      rom_mode = 2;
      ack_delay = 5;
      push_expected(2, 7'd20, 3'd3, 1'b0);
      base = frames_seen;
      start_req(2, 7'd20, 3'd3, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (iic_wr_req && iic_wr_data[15:8] == 8'h40) found = 1'b1;
         else begin
            @(posedge clk_50m); #1;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL abort_reach_data got=timeout want=data_frame");
      end
      len = 6'd5; x = 7'd0; y = 3'd0; start = 1'b1;
      @(posedge clk_50m); #1;
      start = 1'b0; abort = 1'b1;
      @(posedge clk_50m); #1;
      abort = 1'b0;
      wait_done(200, ok);
      checks++;
      if (!ok || (frames_seen - base) != 4) begin
         failures++;
         $display("FAIL abort_frames got=%0d/ok%0d want=4/ok1", frames_seen - base, ok);
      end
      req_hi = 0;
      repeat (10) begin
         @(posedge clk_50m); #1;
         if (iic_wr_req || busy || done) req_hi++;
      end
      checks++;
      if (req_hi != 0) begin
         failures++;
         $display("FAIL abort_quiet got=%0d want=0", req_hi);
      end
      exp_q.delete();
      ack_delay = 3;
   endtask

   task automatic test_reset_mid();
      bit found;
      rom_mode = 2;
      push_expected(1, 7'd9, 3'd4, 1'b0);
      start_req(1, 7'd9, 3'd4, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (iic_wr_req) found = 1'b1;
         else begin
            @(posedge clk_50m); #1;
         end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (!found || {iic_wr_req, busy, done} !== 3'b000 || iic_wr_data !== 24'h0) begin
         failures++;
         $display("FAIL rst_mid got=%b/%h found%0d want=000/000000 found1",
                  {iic_wr_req, busy, done}, iic_wr_data, found);
      end
      exp_q.delete();
      repeat (2) @(posedge clk_50m);
      @(negedge clk_50m);
      rst = 1'b0;
      run_req("after_rst", 2, 7'd9, 3'd4, 1'b0, 44);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; invert = 1'b0; abort = 1'b0;
      len = '0; x = '0; y = '0;
      for (int i = 0; i < 64; i++) str_mem[i] = 8'(8'h41 + i);
      test_reset();
      test_single_char();
      test_wrap();
      test_invert_and_empty();
      test_clamp();
      test_page_wrap();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
